// File: rtl/game_pkg.sv
// Shared board geometry, cell encoding and marker colours for the battleship display.
package game_pkg;

   typedef enum logic [1:0] {
      CellEmpty = 2'd0,
      CellShip  = 2'd1,
      CellMiss  = 2'd2,
      CellHit   = 2'd3
   } cell_state_t;

   typedef enum logic [0:0] {StIdle, StClear} clr_state_t;

   localparam logic [10:0] LeftX    = 11'd96;
   localparam logic [10:0] RightX   = 11'd608;
   localparam logic [10:0] BoardY   = 11'd192;
   localparam logic [10:0] CellSize = 11'd32;
   localparam logic [10:0] BoardW   = 11'd320;
   localparam logic [10:0] BoardH   = 11'd320;
   localparam logic [3:0]  GridN    = 4'd10;
   localparam logic [7:0]  CellCnt  = 8'd200;

   localparam logic [11:0] ShipRgb = 12'h7_7_7;
   localparam logic [11:0] MissRgb = 12'hF_F_F;
   localparam logic [11:0] HitRgb  = 12'hF_0_0;
   localparam logic [4:0]  MissLo  = 5'd12;
   localparam logic [4:0]  MissHi  = 5'd19;

   function automatic logic [7:0] cell_addr(logic board, logic [3:0] row, logic [3:0] col);
      return (board ? 8'd100 : 8'd0) + 8'(row) * 8'd10 + 8'(col);
   endfunction

endpackage

// File: rtl/vga_if.sv
// VGA timing plus rgb stream passed between drawing stages.
interface vga_if;
   logic [10:0] vcount;
   logic        vsync;
   logic        vblnk;
   logic [10:0] hcount;
   logic        hsync;
   logic        hblnk;
   logic [11:0] rgb;

   modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
   modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/cell_ram.sv
// Cell state storage: one write port, one registered read port, contents not reset.
module cell_ram #(
   parameter int unsigned Depth = 200
) (
   input  logic       clk,
   input  logic       we,
   input  logic [7:0] waddr,
   input  logic [1:0] wdata,
   input  logic [7:0] raddr,
   output logic [1:0] rdata
);

   logic [1:0] mem [Depth];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/delay.sv
// Fixed-length register pipeline, reset to zero.
module delay #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned CLK_DEL = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] pipe_q [CLK_DEL];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < CLK_DEL; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= din;
         for (int unsigned i = 1; i < CLK_DEL; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign dout = pipe_q[CLK_DEL-1];

endmodule

// File: rtl/draw_cells.sv
// Overlays hit/miss/ship markers on both 10x10 boards; 2-cycle pipeline, plus board clear FSM.
module draw_cells
   import game_pkg::*;
#(
   parameter bit SHOW_ENEMY_SHIPS = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   vga_if.in          vga_in,
   vga_if.out         vga_out,
   input  logic       wr_en,
   input  logic       wr_board,
   input  logic [3:0] wr_x,
   input  logic [3:0] wr_y,
   input  logic [1:0] wr_state,
   input  logic       clr_req,
   output logic       clr_busy
);

   logic [8:0]  rel_x, rel_y;
   logic        in_left, in_right, in_board;
   logic [7:0]  rd_addr;
   logic [1:0]  rd_data;
   logic        in_board_q, board_q;
   logic [4:0]  off_x_q, off_y_q;
   logic [11:0] rgb_q, rgb_d, rgb_out_q;
   logic [25:0] tim_out;

   clr_state_t  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        ram_we;
   logic [7:0]  ram_waddr;
   logic [1:0]  ram_wdata;

   // Stage 0: locate the pixel; the read address is registered inside cell_ram
   always_comb begin
      in_left  = (vga_in.hcount >= LeftX) && (vga_in.hcount < LeftX + BoardW);
      in_right = (vga_in.hcount >= RightX) && (vga_in.hcount < RightX + BoardW);
      in_board = (in_left || in_right) && !vga_in.hblnk && !vga_in.vblnk &&
                 (vga_in.vcount >= BoardY) && (vga_in.vcount < BoardY + BoardH);
      rel_x    = 9'(vga_in.hcount - (in_right ? RightX : LeftX));
      rel_y    = 9'(vga_in.vcount - BoardY);
      rd_addr  = in_board ? cell_addr(in_right, rel_y[8:5], rel_x[8:5]) : 8'd0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_board_q <= 1'b0;
         board_q    <= 1'b0;
         off_x_q    <= '0;
         off_y_q    <= '0;
         rgb_q      <= '0;
         rgb_out_q  <= '0;
      end else begin
         in_board_q <= in_board;
         board_q    <= in_right;
         off_x_q    <= rel_x[4:0];
         off_y_q    <= rel_y[4:0];
         rgb_q      <= vga_in.rgb;
         rgb_out_q  <= rgb_d;
      end
   end

   // Stage 1 -> 2: grid lines (offset 0) always show the background
   always_comb begin
      rgb_d = rgb_q;
      if (in_board_q && (off_x_q != 5'd0) && (off_y_q != 5'd0)) begin
         case (cell_state_t'(rd_data))
            CellShip: if (!board_q || SHOW_ENEMY_SHIPS) rgb_d = ShipRgb;
            CellMiss: if ((off_x_q inside {[MissLo:MissHi]}) &&
                          (off_y_q inside {[MissLo:MissHi]})) rgb_d = MissRgb;
            CellHit:  rgb_d = HitRgb;
            default:  rgb_d = rgb_q;
         endcase
      end
   end

   delay #(
      .WIDTH   (26),
      .CLK_DEL (2)
   ) u_timing_delay (
      .clk  (clk),
      .rst  (rst),
      .din  ({vga_in.vcount, vga_in.vsync, vga_in.vblnk,
              vga_in.hcount, vga_in.hsync, vga_in.hblnk}),
      .dout (tim_out)
   );

   assign {vga_out.vcount, vga_out.vsync, vga_out.vblnk,
           vga_out.hcount, vga_out.hsync, vga_out.hblnk} = tim_out;
   assign vga_out.rgb = rgb_out_q;

   cell_ram #(
      .Depth (200)
   ) u_cell_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   // Reset lands in StClear so the uninitialised storage is wiped on release
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StClear;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (clr_req) begin
               state_d = StClear;
               cnt_d   = 8'd0;
            end
         end
         StClear: begin
            if (cnt_q == CellCnt - 8'd1) begin
               state_d = StIdle;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      clr_busy  = (state_q == StClear);
      ram_we    = 1'b0;
      ram_waddr = cnt_q;
      ram_wdata = CellEmpty;
      if (state_q == StClear) begin
         ram_we = 1'b1;
      end else if (wr_en && !clr_req && (wr_x < GridN) && (wr_y < GridN)) begin
         ram_we    = 1'b1;
         ram_waddr = cell_addr(wr_board, wr_y, wr_x);
         ram_wdata = wr_state;
      end
   end

endmodule
